// File: rtl/seq_gen_ab.sv
// Serial pattern transmitter for the 01110 detector: sends a parallel word MSB-first,
// two bits per clock on {A,B}, and keeps a reference count of overlapping 01110 hits.
module seq_gen_ab #(
    parameter int SEQUENCE_WIDTH = 24,
    parameter int CNT_WIDTH      = 8
) (
    input  logic                      clk,
    input  logic                      clr,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [SEQUENCE_WIDTH-1:0] in_data,
    output logic                      A,
    output logic                      B,
    output logic                      out_valid,
    output logic                      done,
    output logic [CNT_WIDTH-1:0]      hit_cnt
);

    localparam int PAIRS = SEQUENCE_WIDTH / 2;
    localparam int PW    = $clog2(PAIRS + 1);

    typedef enum logic {
        IDLE,
        SEND
    } state_t;

    state_t                      state, state_next;
    logic [SEQUENCE_WIDTH-1:0]   sr, sr_next;
    logic [PW-1:0]               pair_cnt, pair_cnt_next;
    logic [3:0]                  hist, hist_next;
    logic                        a_next, b_next, ov_next, done_next;
    logic [CNT_WIDTH-1:0]        hit_next;
    logic                        hit_w1, hit_w2;
    logic [1:0]                  hits;
    logic                        handshake;

    assign in_ready  = (state == IDLE) & clr;
    assign handshake = in_valid & in_ready;

    // Both windows end inside the pair currently on {A,B}; the earlier one ends at A.
    always_comb begin
        hit_w1 = ({hist, A} == 5'b01110);
        hit_w2 = ({hist[2:0], A, B} == 5'b01110);
        hits   = {1'b0, hit_w1} + {1'b0, hit_w2};
    end

    always_comb begin
        state_next    = state;
        sr_next       = sr;
        pair_cnt_next = pair_cnt;
        hist_next     = hist;
        a_next        = 1'b0;
        b_next        = 1'b0;
        ov_next       = 1'b0;
        done_next     = 1'b0;
        hit_next      = hit_cnt;
        case (state)
            IDLE: begin
                // The first pair is taken straight from in_data so it shows in the next cycle.
                if (handshake) begin
                    state_next    = SEND;
                    a_next        = in_data[SEQUENCE_WIDTH-1];
                    b_next        = in_data[SEQUENCE_WIDTH-2];
                    ov_next       = 1'b1;
                    sr_next       = in_data << 2;
                    pair_cnt_next = PW'(PAIRS);
                    hist_next     = 4'b0000;
                    hit_next      = '0;
                end
            end
            SEND: begin
                hit_next  = hit_cnt + CNT_WIDTH'(hits);
                hist_next = {hist[1:0], A, B};
                if (pair_cnt == PW'(1)) begin
                    state_next = IDLE;
                    done_next  = 1'b1;
                end else begin
                    a_next        = sr[SEQUENCE_WIDTH-1];
                    b_next        = sr[SEQUENCE_WIDTH-2];
                    ov_next       = 1'b1;
                    sr_next       = sr << 2;
                    pair_cnt_next = pair_cnt - PW'(1);
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!clr) begin
            state     <= IDLE;
            sr        <= '0;
            pair_cnt  <= '0;
            hist      <= 4'b0000;
            A         <= 1'b0;
            B         <= 1'b0;
            out_valid <= 1'b0;
            done      <= 1'b0;
            hit_cnt   <= '0;
        end else begin
            state     <= state_next;
            sr        <= sr_next;
            pair_cnt  <= pair_cnt_next;
            hist      <= hist_next;
            A         <= a_next;
            B         <= b_next;
            out_valid <= ov_next;
            done      <= done_next;
            hit_cnt   <= hit_next;
        end
    end

endmodule

// File: tb/tb_seq_gen_ab.sv
// Directed bench for seq_gen_ab: expected pairs and hit counts are queued when a word
// is offered and checked by a negedge monitor as the DUT emits them.
module tb_seq_gen_ab;

    localparam int W     = 24;
    localparam int CW    = 8;
    localparam int PAIRS = W / 2;

    logic          clk = 1'b0;
    logic          clr = 1'b0;
    logic          in_valid = 1'b0;
    logic [W-1:0]  in_data = '0;
    logic          in_ready, A, B, out_valid, done;
    logic [CW-1:0] hit_cnt;

    int compared   = 0;
    int mismatched = 0;

    logic [1:0]    pair_q[$];
    logic [CW-1:0] hit_q[$];

    always #5 clk = ~clk;

    seq_gen_ab #(.SEQUENCE_WIDTH(W), .CNT_WIDTH(CW)) dut (
        .clk(clk), .clr(clr), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .A(A), .B(B), .out_valid(out_valid),
        .done(done), .hit_cnt(hit_cnt)
    );

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compared++;
        assert (observed === expected) else begin
            mismatched++;
            $error("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    // Scoreboard side: every valid pair and every done pulse must match the next queued value.
    always @(negedge clk) begin
        logic [1:0]    exp_pair;
        logic [CW-1:0] exp_hits;
        if (out_valid === 1'b1) begin
            if (pair_q.size() == 0) checkOutput("unexpected_pair", 32'(out_valid), 32'd0);
            else begin
                exp_pair = pair_q.pop_front();
                checkOutput("pair", 32'({A, B}), 32'(exp_pair));
            end
        end
        if (done === 1'b1) begin
            if (hit_q.size() == 0) checkOutput("unexpected_done", 32'(done), 32'd0);
            else begin
                exp_hits = hit_q.pop_front();
                checkOutput("hit_cnt_at_done", 32'(hit_cnt), 32'(exp_hits));
            end
        end
    end

    // Called at a negedge; offers the word for one edge and queues its expected output.
    task automatic applyStimulus(input logic [W-1:0] word, input logic [CW-1:0] exp_hits);
        int waited = 0;
        while (in_ready !== 1'b1 && waited < 40) begin
            @(negedge clk);
            waited++;
        end
        checkOutput("ready_before_word", 32'(in_ready), 32'd1);
        in_valid = 1'b1;
        in_data  = word;
        for (int i = PAIRS - 1; i >= 0; i--) pair_q.push_back(word[2*i+1 -: 2]);
        hit_q.push_back(exp_hits);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic waitDone(input int exp_cycles);
        int n = 0;
        while (n < 40) begin
            if (done === 1'b1) break;
            checkOutput("ready_in_send", 32'(in_ready), 32'd0);
            @(negedge clk);
            n++;
        end
        checkOutput("done_latency", 32'(n), 32'(exp_cycles));
        checkOutput("ready_at_done", 32'(in_ready), 32'd1);
        checkOutput("ov_at_done", 32'(out_valid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("[TB] FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        // Reset state
        clr = 1'b0;
        repeat (3) @(negedge clk);
        checkOutput("rst_A", 32'(A), 32'd0);
        checkOutput("rst_B", 32'(B), 32'd0);
        checkOutput("rst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("rst_done", 32'(done), 32'd0);
        checkOutput("rst_hit_cnt", 32'(hit_cnt), 32'd0);
        checkOutput("rst_ready_low", 32'(in_ready), 32'd0);
        clr = 1'b1;
        #1;
        checkOutput("ready_after_rst", 32'(in_ready), 32'd1);

        // Reference word with five overlapping hits
        applyStimulus(24'b011101110111001110001110, 8'd5);
        waitDone(12);
        @(negedge clk);
        checkOutput("done_one_cycle", 32'(done), 32'd0);
        checkOutput("hit_cnt_held", 32'(hit_cnt), 32'd5);
        checkOutput("idle_A", 32'(A), 32'd0);

        // All zeros and all ones
        applyStimulus(24'h000000, 8'd0);
        waitDone(12);
        @(negedge clk);
        applyStimulus(24'hFFFFFF, 8'd0);
        waitDone(12);
        @(negedge clk);

        // Back-to-back with in_valid held high
        in_valid = 1'b1;
        in_data  = 24'b011100000000000000000000;
        for (int i = PAIRS - 1; i >= 0; i--) pair_q.push_back(in_data[2*i+1 -: 2]);
        hit_q.push_back(8'd1);
        @(negedge clk);
        in_data = 24'h00000E;
        for (int i = PAIRS - 1; i >= 0; i--) pair_q.push_back(in_data[2*i+1 -: 2]);
        hit_q.push_back(8'd1);
        waitDone(12);
        @(negedge clk);
        checkOutput("b2b_second_starts", 32'(out_valid), 32'd1);
        in_valid = 1'b0;
        waitDone(12);
        @(negedge clk);

        // A 01110 split across two words must not count
        in_valid = 1'b1;
        in_data  = 24'h000007;
        for (int i = PAIRS - 1; i >= 0; i--) pair_q.push_back(in_data[2*i+1 -: 2]);
        hit_q.push_back(8'd0);
        @(negedge clk);
        in_data = 24'h400000;
        for (int i = PAIRS - 1; i >= 0; i--) pair_q.push_back(in_data[2*i+1 -: 2]);
        hit_q.push_back(8'd0);
        waitDone(12);
        @(negedge clk);
        in_valid = 1'b0;
        waitDone(12);
        @(negedge clk);

        // Inputs wiggled during SEND must be ignored
        applyStimulus(24'h0E0E0E, 8'd3);
        for (int i = 0; i < 10; i++) begin
            in_valid = i[0];
            in_data  = W'($urandom);
            checkOutput("ignore_ready", 32'(in_ready), 32'd0);
            checkOutput("ignore_done", 32'(done), 32'd0);
            @(negedge clk);
        end
        in_valid = 1'b0;
        waitDone(2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            checkOutput("no_extra_done", 32'(done), 32'd0);
            checkOutput("no_extra_pair", 32'(out_valid), 32'd0);
        end

        // Reset asserted while pair 6 is on the outputs
        applyStimulus(24'h0E0E0E, 8'd3);
        repeat (5) @(negedge clk);
        clr = 1'b0;
        @(negedge clk);
        checkOutput("midrst_A", 32'(A), 32'd0);
        checkOutput("midrst_B", 32'(B), 32'd0);
        checkOutput("midrst_out_valid", 32'(out_valid), 32'd0);
        checkOutput("midrst_done", 32'(done), 32'd0);
        checkOutput("midrst_hit_cnt", 32'(hit_cnt), 32'd0);
        checkOutput("midrst_ready_low", 32'(in_ready), 32'd0);
        pair_q.delete();
        hit_q.delete();
        clr = 1'b1;
        #1;
        checkOutput("midrst_ready_high", 32'(in_ready), 32'd1);
        applyStimulus(24'hC00003, 8'd0);
        waitDone(12);
        @(negedge clk);

        checkOutput("pairs_left", 32'(pair_q.size()), 32'd0);
        checkOutput("hits_left", 32'(hit_q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
